spi_slave: RTL



---
 rtl/spi_shared_pkg.sv | 22 ++
 rtl/spi_tx_serializer.sv | 58 +++++
 rtl/spi_slave.sv | 165 ++++++++++++++++
 3 files changed

// File: rtl/spi_shared_pkg.sv
// Shared definitions for the SPI slave front end: FSM state encodings,
// command codes and default widths.
package spi_shared_pkg;

    localparam int RX_W_DEF        = 10;
    localparam int TX_W_DEF        = 8;
    localparam int TX_WAIT_MAX_DEF = 15;

    typedef logic [2:0] state_t;

    localparam state_t IDLE      = 3'd0;
    localparam state_t CHK_CMD   = 3'd1;
    localparam state_t WRITE     = 3'd2;
    localparam state_t READ_ADD  = 3'd3;
    localparam state_t READ_DATA = 3'd4;

    localparam logic [1:0] CMD_WR_ADDR = 2'b00;
    localparam logic [1:0] CMD_WR_DATA = 2'b01;
    localparam logic [1:0] CMD_RD_ADDR = 2'b10;
    localparam logic [1:0] CMD_RD_DATA = 2'b11;

endpackage

// File: rtl/spi_tx_serializer.sv
// Read-return serializer: loads a RAM read word and shifts it onto MISO,
// MSB first, one bit per clock. clr (slave deselected) truncates any shift.
module spi_tx_serializer
    import spi_shared_pkg::*;
#(
    parameter int TX_W = TX_W_DEF
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            clr,
    input  logic            load,
    input  logic [TX_W-1:0] tx_data,
    output logic            miso,
    output logic            done
);

    localparam int CNT_W = $clog2(TX_W);

    logic [TX_W-2:0]  sreg;
    logic [CNT_W-1:0] remain;
    logic             busy;

    // Shift engine: MSB goes out the cycle after load, remaining bits follow.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sreg   <= '0;
            remain <= '0;
            busy   <= 1'b0;
            miso   <= 1'b0;
            done   <= 1'b0;
        end else if (clr) begin
            sreg   <= '0;
            remain <= '0;
            busy   <= 1'b0;
            miso   <= 1'b0;
            done   <= 1'b0;
        end else if (load) begin
            miso   <= tx_data[TX_W-1];
            sreg   <= tx_data[TX_W-2:0];
            remain <= CNT_W'(TX_W - 1);
            busy   <= 1'b1;
            done   <= 1'b0;
        end else if (busy) begin
            if (remain == '0) begin
                miso <= 1'b0;
                busy <= 1'b0;
                done <= 1'b1;
            end else begin
                miso   <= sreg[TX_W-2];
                sreg   <= {sreg[TX_W-3:0], 1'b0};
                remain <= remain - CNT_W'(1);
            end
        end else begin
            miso <= 1'b0;
        end
    end

endmodule

// File: rtl/spi_slave.sv
// SPI slave front end for the single-port RAM. Assembles 10-bit frames from
// MOSI into rx_data/rx_valid and returns read data on MISO.
// Optional feature macro: SPI_ABORT_CNT_EN adds the abort_cnt output, which
// counts truncated frames and abandoned reads (saturating at 255).
module spi_slave
    import spi_shared_pkg::*;
#(
    parameter int RX_W        = RX_W_DEF,
    parameter int TX_W        = TX_W_DEF,
    parameter int TX_WAIT_MAX = TX_WAIT_MAX_DEF
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            SS_n,
    input  logic            MOSI,
    output logic            MISO,
    output logic [RX_W-1:0] rx_data,
    output logic            rx_valid,
`ifdef SPI_ABORT_CNT_EN
    output logic [7:0]      abort_cnt,
`endif
    input  logic [TX_W-1:0] tx_data,
    input  logic            tx_valid
);

    localparam int CNT_W  = $clog2(RX_W + 1);
    localparam int WAIT_W = $clog2(TX_WAIT_MAX + 1);

    state_t            state;
    logic [CNT_W-1:0]  bit_cnt;
    logic [RX_W-2:0]   shift_r;
    logic              rd_addr_seen;
    logic              waiting;
    logic [WAIT_W-1:0] wait_cnt;

    logic              frame_done_s;
    logic              load_s;
    logic              wait_expire_s;
    logic              ser_done_s;

    // Qualifiers for the read-return wait window.
    always_comb begin
        frame_done_s  = (bit_cnt == CNT_W'(RX_W));
        load_s        = 1'b0;
        wait_expire_s = 1'b0;
        if (!SS_n && (state == READ_DATA) && waiting) begin
            load_s        = tx_valid && !ser_done_s;
            wait_expire_s = !tx_valid && (wait_cnt == WAIT_W'(TX_WAIT_MAX - 1));
        end else begin
            load_s        = 1'b0;
            wait_expire_s = 1'b0;
        end
    end

    // Frame FSM: command decode, bit collection, completion strobe and wait window.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            bit_cnt      <= '0;
            shift_r      <= '0;
            rx_data      <= '0;
            rx_valid     <= 1'b0;
            rd_addr_seen <= 1'b0;
            waiting      <= 1'b0;
            wait_cnt     <= '0;
        end else begin
            rx_valid <= 1'b0;
            if (SS_n) begin
                state    <= IDLE;
                bit_cnt  <= '0;
                waiting  <= 1'b0;
                wait_cnt <= '0;
            end else begin
                case (state)
                    IDLE: begin
                        state   <= CHK_CMD;
                        bit_cnt <= '0;
                    end
                    CHK_CMD: begin
                        shift_r <= {{(RX_W-2){1'b0}}, MOSI};
                        bit_cnt <= CNT_W'(1);
                        if (!MOSI) begin
                            state <= WRITE;
                        end else if (!rd_addr_seen) begin
                            state <= READ_ADD;
                        end else begin
                            state <= READ_DATA;
                        end
                    end
                    WRITE, READ_ADD, READ_DATA: begin
                        if (bit_cnt == CNT_W'(RX_W - 1)) begin
                            // Last bit: publish the whole frame in one step.
                            rx_data  <= {shift_r, MOSI};
                            rx_valid <= 1'b1;
                            bit_cnt  <= CNT_W'(RX_W);
                            if (state == READ_ADD) begin
                                rd_addr_seen <= 1'b1;
                            end else if (state == READ_DATA) begin
                                rd_addr_seen <= 1'b0;
                                waiting      <= 1'b1;
                                wait_cnt     <= '0;
                            end else begin
                                rd_addr_seen <= rd_addr_seen;
                            end
                        end else if (!frame_done_s) begin
                            shift_r <= {shift_r[RX_W-3:0], MOSI};
                            bit_cnt <= bit_cnt + CNT_W'(1);
                        end else if (waiting) begin
                            if (load_s || wait_expire_s) begin
                                waiting <= 1'b0;
                            end else begin
                                wait_cnt <= wait_cnt + WAIT_W'(1);
                            end
                        end else begin
                            bit_cnt <= bit_cnt;
                        end
                    end
                    default: begin
                        state   <= IDLE;
                        bit_cnt <= '0;
                    end
                endcase
            end
        end
    end

`ifdef SPI_ABORT_CNT_EN
    logic abort_evt_s;

    // Abort events: deselect before the frame completes, or read wait expiry.
    always_comb begin
        if (SS_n && (state != IDLE) && !frame_done_s) begin
            abort_evt_s = 1'b1;
        end else if (wait_expire_s) begin
            abort_evt_s = 1'b1;
        end else begin
            abort_evt_s = 1'b0;
        end
    end

    // Saturating abort counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            abort_cnt <= 8'd0;
        end else if (abort_evt_s && (abort_cnt != 8'd255)) begin
            abort_cnt <= abort_cnt + 8'd1;
        end else begin
            abort_cnt <= abort_cnt;
        end
    end
`endif

    spi_tx_serializer #(
        .TX_W (TX_W)
    ) u_tx (
        .clk     (clk),
        .rst_n   (rst_n),
        .clr     (SS_n),
        .load    (load_s),
        .tx_data (tx_data),
        .miso    (MISO),
        .done    (ser_done_s)
    );

endmodule
